mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (cpu / ext) arbiter in front of a single data memory.
// Grants are combinational from the live requests and the registered owner
// state. The ext port has two ways to win over the cpu:
//   - an anti-starvation counter
//   - a locked burst, which is capped so the cpu cannot be shut out forever.
// Read data is captured at the grant-cycle edge and returned with a
// one-cycle rvalid strobe on the requesting port.
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int STARVE_MAX = 3,
    parameter int BURST_MAX  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    // cpu port
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [DATA_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wd,
    input  logic [2:0]            cpu_funct3,
    // ext port
    input  logic                  ext_req,
    input  logic                  ext_we,
    input  logic                  ext_lock,
    input  logic [DATA_WIDTH-1:0] ext_addr,
    input  logic [DATA_WIDTH-1:0] ext_wd,
    input  logic [2:0]            ext_funct3,
    // grants and read returns
    output logic                  cpu_gnt,
    output logic                  ext_gnt,
    output logic                  cpu_stall,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] ext_rdata,
    output logic                  ext_rvalid,
    // data memory side
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wd,
    output logic                  mem_we,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_WIDTH-1:0] mem_rd
);

    // Owner of the previous cycle. EXT and EXT_LOCKED both count as existing
    // ext ownership; EXT_LOCKED marks that the grant was held by the lock.
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_CPU        = 2'd1,
        ST_EXT        = 2'd2,
        ST_EXT_LOCKED = 2'd3
    } state_t;

    localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);
    localparam logic [3:0] BURST_LIMIT  = 4'(BURST_MAX);
    localparam int         NUM_PORTS    = 2;

    state_t     state_reg;
    state_t     state_next;
    logic [3:0] starve_reg;
    logic [3:0] starve_next;
    logic [3:0] burst_reg;
    logic [3:0] burst_next;

    logic       cpu_gnt_next;
    logic       ext_gnt_next;
    logic       ext_owner;
    logic       burst_done;
    logic       starved;

    // Per-port views so both read-return paths share one generate body.
    // Index 0 is the cpu port and index 1 is the ext port.
    logic                  port_gnt   [NUM_PORTS];
    logic                  port_we    [NUM_PORTS];
    logic [DATA_WIDTH-1:0] rdata_reg  [NUM_PORTS];
    logic                  rvalid_reg [NUM_PORTS];

    // Conditions that bend the default cpu-first priority.
    assign ext_owner  = (state_reg == ST_EXT) || (state_reg == ST_EXT_LOCKED);
    assign burst_done = cpu_req && (burst_reg >= BURST_LIMIT);
    assign starved    = ext_req && (starve_reg >= STARVE_LIMIT);

    // Owner state register; the reset abandons any lock in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Grant decision and next owner. The burst cap beats the lock, the lock
    // beats starvation, and starvation beats the plain cpu priority.
    always_comb begin
        cpu_gnt_next = 1'b0;
        ext_gnt_next = 1'b0;
        state_next   = ST_IDLE;
        if (!rst) begin
            if (burst_done) begin
                cpu_gnt_next = 1'b1;
                state_next   = ST_CPU;
            end else if (ext_owner && ext_req && ext_lock) begin
                ext_gnt_next = 1'b1;
                state_next   = ST_EXT_LOCKED;
            end else if (starved) begin
                ext_gnt_next = 1'b1;
                state_next   = ST_EXT;
            end else if (cpu_req) begin
                cpu_gnt_next = 1'b1;
                state_next   = ST_CPU;
            end else if (ext_req) begin
                ext_gnt_next = 1'b1;
                state_next   = ST_EXT;
            end
        end
    end

    assign cpu_gnt   = cpu_gnt_next;
    assign ext_gnt   = ext_gnt_next;
    assign cpu_stall = cpu_req & ~cpu_gnt_next;

    // Next values of the starve and burst counters; both saturate at 15.
    // The burst counter only advances for locked grants that hold off a
    // waiting cpu, and it holds when the cpu is not waiting.
    always_comb begin
        starve_next = 4'd0;
        burst_next  = 4'd0;
        if (ext_req && !ext_gnt_next) begin
            starve_next = (starve_reg == 4'hF) ? 4'hF : starve_reg + 4'd1;
        end
        if (ext_gnt_next) begin
            burst_next = burst_reg;
            if (ext_lock && cpu_req) begin
                burst_next = (burst_reg == 4'hF) ? 4'hF : burst_reg + 4'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_reg <= 4'd0;
            burst_reg  <= 4'd0;
        end else begin
            starve_reg <= starve_next;
            burst_reg  <= burst_next;
        end
    end

    // Memory-side mux: drive the granted port's fields, or all zeros when idle.
    always_comb begin
        mem_addr   = '0;
        mem_wd     = '0;
        mem_we     = 1'b0;
        mem_funct3 = 3'd0;
        if (cpu_gnt_next) begin
            mem_addr   = cpu_addr;
            mem_wd     = cpu_wd;
            mem_we     = cpu_we;
            mem_funct3 = cpu_funct3;
        end else if (ext_gnt_next) begin
            mem_addr   = ext_addr;
            mem_wd     = ext_wd;
            mem_we     = ext_we;
            mem_funct3 = ext_funct3;
        end
    end

    assign port_gnt[0] = cpu_gnt_next;
    assign port_we[0]  = cpu_we;
    assign port_gnt[1] = ext_gnt_next;
    assign port_we[1]  = ext_we;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_ret
            // Read return for one port. rdata is captured on a granted read
            // and then held; rvalid pulses for the cycle after the grant.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdata_reg[gi]  <= '0;
                    rvalid_reg[gi] <= 1'b0;
                end else begin
                    rvalid_reg[gi] <= port_gnt[gi] & ~port_we[gi];
                    if (port_gnt[gi] && !port_we[gi]) begin
                        rdata_reg[gi] <= mem_rd;
                    end
                end
            end
        end
    endgenerate

    assign cpu_rdata  = rdata_reg[0];
    assign cpu_rvalid = rvalid_reg[0];
    assign ext_rdata  = rdata_reg[1];
    assign ext_rvalid = rvalid_reg[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a fixed grant table, hand-written corner
// sequences, and randomized traffic checked against a reference model.
module tb_mem_arbiter;

    localparam int DW   = 32;
    localparam int SMAX = 3;
    localparam int BMAX = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we, ext_req, ext_we, ext_lock;
    logic [DW-1:0] cpu_addr, cpu_wd, ext_addr, ext_wd, mem_rd;
    logic [2:0]    cpu_funct3, ext_funct3;
    logic          cpu_gnt, ext_gnt, cpu_stall, cpu_rvalid, ext_rvalid, mem_we;
    logic [DW-1:0] cpu_rdata, ext_rdata, mem_addr, mem_wd;
    logic [2:0]    mem_funct3;

    mem_arbiter #(.DATA_WIDTH(DW), .STARVE_MAX(SMAX), .BURST_MAX(BMAX)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
        .cpu_funct3(cpu_funct3),
        .ext_req(ext_req), .ext_we(ext_we), .ext_lock(ext_lock), .ext_addr(ext_addr),
        .ext_wd(ext_wd), .ext_funct3(ext_funct3),
        .cpu_gnt(cpu_gnt), .ext_gnt(ext_gnt), .cpu_stall(cpu_stall),
        .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
        .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we),
        .mem_funct3(mem_funct3), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: who owned the memory last cycle (0 none, 1 cpu, 2 ext),
    // how long ext has waited, and how many locked ext grants held off the cpu.
    int            m_owner;
    int            m_starve;
    int            m_burst;
    logic [DW-1:0] m_cpu_rdata, m_ext_rdata;
    logic          m_cpu_rvalid, m_ext_rvalid;
    logic          e_cpu_gnt, e_ext_gnt;

    function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        m_owner      = 0;
        m_starve     = 0;
        m_burst      = 0;
        m_cpu_rdata  = '0;
        m_ext_rdata  = '0;
        m_cpu_rvalid = 1'b0;
        m_ext_rvalid = 1'b0;
    endfunction

    // Who wins this cycle, from the arbitration rules.
    function automatic void model_grant();
        e_cpu_gnt = 1'b0;
        e_ext_gnt = 1'b0;
        if (!rst) begin
            if (cpu_req && m_burst >= BMAX)                  e_cpu_gnt = 1'b1;
            else if (m_owner == 2 && ext_req && ext_lock)    e_ext_gnt = 1'b1;
            else if (ext_req && m_starve >= SMAX)            e_ext_gnt = 1'b1;
            else if (cpu_req)                                e_cpu_gnt = 1'b1;
            else if (ext_req)                                e_ext_gnt = 1'b1;
        end
    endfunction

    // Advance the model across one rising clock edge.
    function automatic void model_update();
        model_grant();
        if (rst) begin
            model_reset();
        end else begin
            m_cpu_rvalid = e_cpu_gnt && !cpu_we;
            m_ext_rvalid = e_ext_gnt && !ext_we;
            if (m_cpu_rvalid) m_cpu_rdata = mem_rd;
            if (m_ext_rvalid) m_ext_rdata = mem_rd;
            m_starve = (ext_req && !e_ext_gnt) ? ((m_starve < 15) ? m_starve + 1 : 15) : 0;
            if (!e_ext_gnt) m_burst = 0;
            else if (ext_lock && cpu_req && m_burst < 15) m_burst = m_burst + 1;
            m_owner = e_cpu_gnt ? 1 : (e_ext_gnt ? 2 : 0);
        end
    endfunction

    task automatic check_all(string tag);
        logic [DW-1:0] ea, ew;
        logic          ewe;
        logic [2:0]    ef;
        model_grant();
        ea  = e_cpu_gnt ? cpu_addr   : (e_ext_gnt ? ext_addr   : '0);
        ew  = e_cpu_gnt ? cpu_wd     : (e_ext_gnt ? ext_wd     : '0);
        ewe = e_cpu_gnt ? cpu_we     : (e_ext_gnt ? ext_we     : 1'b0);
        ef  = e_cpu_gnt ? cpu_funct3 : (e_ext_gnt ? ext_funct3 : 3'd0);
        chk({tag, " cpu_gnt"},    DW'(cpu_gnt),    DW'(e_cpu_gnt));
        chk({tag, " ext_gnt"},    DW'(ext_gnt),    DW'(e_ext_gnt));
        chk({tag, " cpu_stall"},  DW'(cpu_stall),  DW'(cpu_req && !e_cpu_gnt));
        chk({tag, " mem_we"},     DW'(mem_we),     DW'(ewe));
        chk({tag, " mem_addr"},   mem_addr,        ea);
        chk({tag, " mem_wd"},     mem_wd,          ew);
        chk({tag, " mem_funct3"}, DW'(mem_funct3), DW'(ef));
        chk({tag, " cpu_rvalid"}, DW'(cpu_rvalid), DW'(m_cpu_rvalid));
        chk({tag, " ext_rvalid"}, DW'(ext_rvalid), DW'(m_ext_rvalid));
        chk({tag, " cpu_rdata"},  cpu_rdata,       m_cpu_rdata);
        chk({tag, " ext_rdata"},  ext_rdata,       m_ext_rdata);
    endtask

    // Inputs are driven just after a falling edge. settle moves to just before
    // the rising edge; finish_cycle crosses the edge and returns to the next
    // falling edge.
    task automatic settle();
        #4;
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic step(string tag);
        settle();
        check_all(tag);
        finish_cycle();
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; ext_req = 0; ext_we = 0; ext_lock = 0;
        cpu_addr = '0; cpu_wd = '0; ext_addr = '0; ext_wd = '0;
        cpu_funct3 = 3'd0; ext_funct3 = 3'd2; mem_rd = '0;
    endtask

    task automatic randomize_fields();
        cpu_addr = $urandom; cpu_wd = $urandom; ext_addr = $urandom; ext_wd = $urandom;
        cpu_funct3 = 3'($urandom_range(7)); ext_funct3 = 3'($urandom_range(7));
        mem_rd = $urandom;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        step("reset");
        rst = 1'b0;
    endtask

    typedef struct {
        logic cr, er, el;
        logic gc, ge;
    } vec_t;

    vec_t tbl[22];

    function automatic void setv(int i, logic cr, logic er, logic el, logic gc, logic ge);
        tbl[i] = '{cr: cr, er: er, el: el, gc: gc, ge: ge};
    endfunction

    initial begin
        // Grant sequence from a fresh reset with STARVE_MAX=3 and BURST_MAX=8.
        setv(0, 0, 0, 0, 0, 0);                              // no requests
        for (int i = 1; i <= 3; i++) setv(i, 1, 1, 1, 1, 0); // cpu wins while ext starves
        for (int i = 4; i <= 11; i++) setv(i, 1, 1, 1, 0, 1);// starve grant + 7 locked = 8
        setv(12, 1, 1, 1, 1, 0);                             // burst cap returns cpu
        setv(13, 1, 1, 1, 1, 0);                             // lock ignored in CPU
        setv(14, 1, 1, 1, 1, 0);
        setv(15, 1, 1, 1, 0, 1);                             // starved again
        setv(16, 0, 1, 1, 0, 1);                             // lock holds
        setv(17, 0, 0, 0, 0, 0);                             // idle
        setv(18, 0, 1, 1, 0, 1);                             // ext from IDLE
        setv(19, 1, 1, 1, 0, 1);                             // lock extends ownership
        setv(20, 1, 0, 0, 1, 0);
        setv(21, 1, 1, 1, 1, 0);                             // CPU owner, lock ignored

        idle_inputs();
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst cpu_gnt",    DW'(cpu_gnt),    '0);
        chk("rst ext_gnt",    DW'(ext_gnt),    '0);
        chk("rst cpu_rvalid", DW'(cpu_rvalid), '0);
        chk("rst ext_rvalid", DW'(ext_rvalid), '0);
        chk("rst cpu_rdata",  cpu_rdata,       '0);
        chk("rst ext_rdata",  ext_rdata,       '0);
        @(negedge clk);
        // Requests are ignored while reset is held.
        cpu_req = 1; ext_req = 1; ext_we = 1;
        settle();
        chk("rst hold cpu_gnt", DW'(cpu_gnt),   '0);
        chk("rst hold mem_we",  DW'(mem_we),    '0);
        chk("rst hold stall",   DW'(cpu_stall), 32'd1);
        finish_cycle();
        idle_inputs();
        rst = 1'b0;

        // Table-driven grant sequence.
        for (int i = 0; i < 22; i++) begin
            cpu_req = tbl[i].cr; ext_req = tbl[i].er; ext_lock = tbl[i].el;
            cpu_we = 1'($urandom_range(1)); ext_we = 1'($urandom_range(1));
            randomize_fields();
            settle();
            chk($sformatf("tbl[%0d] cpu_gnt", i), DW'(cpu_gnt), DW'(tbl[i].gc));
            chk($sformatf("tbl[%0d] ext_gnt", i), DW'(ext_gnt), DW'(tbl[i].ge));
            check_all($sformatf("tbl[%0d]", i));
            finish_cycle();
        end

        // Single cpu read returns mem_rd one cycle later and then holds it.
        idle_inputs();
        do_reset();
        cpu_req = 1; cpu_addr = 32'h10; mem_rd = 32'hDEADBEEF;
        settle();
        chk("rd cpu_gnt",  DW'(cpu_gnt), 32'd1);
        chk("rd mem_addr", mem_addr,     32'h10);
        check_all("rd");
        finish_cycle();
        idle_inputs();
        settle();
        chk("rd cpu_rvalid", DW'(cpu_rvalid), 32'd1);
        chk("rd cpu_rdata",  cpu_rdata,       32'hDEADBEEF);
        check_all("rd+1");
        finish_cycle();
        settle();
        chk("rd+2 cpu_rvalid", DW'(cpu_rvalid), '0);
        chk("rd+2 cpu_rdata",  cpu_rdata,       32'hDEADBEEF);
        check_all("rd+2");
        finish_cycle();

        // ext write with the cpu idle goes straight to memory, with no rvalid.
        ext_req = 1; ext_we = 1; ext_addr = 32'h20; ext_wd = 32'h55;
        settle();
        chk("wr ext_gnt",  DW'(ext_gnt), 32'd1);
        chk("wr mem_we",   DW'(mem_we),  32'd1);
        chk("wr mem_addr", mem_addr,     32'h20);
        chk("wr mem_wd",   mem_wd,       32'h55);
        finish_cycle();
        idle_inputs();
        settle();
        chk("wr+1 ext_rvalid", DW'(ext_rvalid), '0);
        check_all("wr+1");
        finish_cycle();

        // Reset in the middle of a locked ext read burst.
        cpu_req = 1; ext_req = 1; ext_lock = 1; mem_rd = 32'hCAFE0001;
        for (int i = 0; i < 5; i++) step($sformatf("pre-rst[%0d]", i));
        chk("pre-rst ext_rvalid", DW'(ext_rvalid), 32'd1);
        rst = 1'b1; ext_we = 1;
        model_reset();
        #1;
        chk("mid-rst cpu_gnt",    DW'(cpu_gnt),    '0);
        chk("mid-rst ext_gnt",    DW'(ext_gnt),    '0);
        chk("mid-rst ext_rvalid", DW'(ext_rvalid), '0);
        chk("mid-rst mem_we",     DW'(mem_we),     '0);
        chk("mid-rst cpu_stall",  DW'(cpu_stall),  32'd1);
        #3;
        check_all("mid-rst");
        finish_cycle();
        rst = 1'b0; ext_we = 0;
        settle();
        chk("post-rst cpu_gnt", DW'(cpu_gnt), 32'd1);
        check_all("post-rst");
        finish_cycle();

        // No requests: no grant and memory outputs idle.
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("idle mem_we",   DW'(mem_we), '0);
            chk("idle mem_addr", mem_addr,    '0);
            check_all("idle");
            finish_cycle();
        end

        // Randomized traffic against the reference model, with rare resets.
        for (int i = 0; i < 800; i++) begin
            cpu_req  = ($urandom_range(99) < 65);
            ext_req  = ($urandom_range(99) < 70);
            ext_lock = ($urandom_range(99) < 70);
            cpu_we   = 1'($urandom_range(1));
            ext_we   = 1'($urandom_range(1));
            randomize_fields();
            if ($urandom_range(99) < 2) begin
                rst = 1'b1;
                model_reset();
            end else begin
                rst = 1'b0;
            end
            step($sformatf("rnd[%0d]", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
